// File: rtl/iter_shifter.sv
// Iterative shift/rotate unit: SLL, SRL, SRA and ROR, up to STEP bits per cycle.
// A start/busy/done handshake; the controller stalls the PC while busy is high.
module iter_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // STEP may equal WIDTH, so the compare uses one extra bit.
    localparam logic [SHAMT_W:0]   STEP_L  = (SHAMT_W+1)'(STEP);
    localparam logic [SHAMT_W-1:0] STEP_S  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W:0]   WIDTH_L = (SHAMT_W+1)'(WIDTH);

    state_t             r_state;
    state_t             w_state_n;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_rem;
    logic [1:0]         r_op;

    logic               w_load;
    logic               w_step;
    logic [SHAMT_W-1:0] w_s;
    logic [SHAMT_W-1:0] w_rem_n;
    logic [SHAMT_W:0]   w_rot_l;
    logic [WIDTH-1:0]   w_acc_sh;

    // Step size: min(STEP, rem); when STEP==WIDTH rem always wins.
    always_comb begin
        w_s     = ({1'b0, r_rem} < STEP_L) ? r_rem : STEP_S;
        w_rem_n = r_rem - w_s;
        w_rot_l = WIDTH_L - {1'b0, w_s};
    end

    // One partial shift of the accumulator by w_s bits.
    always_comb begin
        w_acc_sh = r_acc;
        unique case (r_op)
            OP_SLL: w_acc_sh = r_acc << w_s;
            OP_SRL: w_acc_sh = r_acc >> w_s;
            OP_SRA: w_acc_sh = unsigned'($signed(r_acc) >>> w_s);
            OP_ROR: w_acc_sh = (r_acc >> w_s) | (r_acc << w_rot_l);
            default: w_acc_sh = r_acc;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next state and datapath enables; DONE can reload with no bubble.
    always_comb begin
        w_state_n = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_state_n = (shamt == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                w_step = 1'b1;
                if (w_rem_n == '0) begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_state_n = (shamt == '0) ? S_DONE : S_BUSY;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then iterative shifting while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_rem <= '0;
            r_op  <= OP_SLL;
        end else if (w_load) begin
            r_acc <= a;
            r_rem <= shamt;
            r_op  <= op;
        end else if (w_step) begin
            r_acc <= w_acc_sh;
            r_rem <= w_rem_n;
        end
    end

    assign busy   = (r_state == S_BUSY);
    assign done   = (r_state == S_DONE);
    assign result = r_acc;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: a STEP=1 and a STEP=4 instance share stimulus.
// Table vectors check result, latency and busy length; sequences cover corners.
module tb_iter_shifter;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy1, done1, busy4, done4;
    logic [31:0] res1, res4;

    int n_checks;
    int n_fail;

    iter_shifter #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .shamt(shamt),
        .busy(busy1), .done(done1), .result(res1)
    );

    iter_shifter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .shamt(shamt),
        .busy(busy4), .done(done4), .result(res4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called #1 after edge number c0 counted from the accept edge (=1).
    task automatic wait_both(input int c0, input logic [31:0] e1,
                             input logic [31:0] e4, input int l1,
                             input int l4, input bit chk_busy,
                             input int eb1, input int eb4, input string tag);
        int c;
        int lat1, lat4, b1, b4;
        logic [31:0] r1, r4;
        c = c0;
        lat1 = 0; lat4 = 0; b1 = 0; b4 = 0;
        r1 = '0; r4 = '0;
        while (c < 80) begin
            if (lat1 == 0) begin
                if (done1) begin lat1 = c; r1 = res1; end
                else if (busy1) b1++;
            end
            if (lat4 == 0) begin
                if (done4) begin lat4 = c; r4 = res4; end
                else if (busy4) b4++;
            end
            if (lat1 != 0 && lat4 != 0) break;
            @(posedge clk); #1;
            c++;
        end
        chk({tag, " res s1"}, res1 === r1 ? r1 : res1, e1);
        chk({tag, " res s4"}, r4, e4);
        chk({tag, " lat s1"}, 32'(lat1), 32'(l1));
        chk({tag, " lat s4"}, 32'(lat4), 32'(l4));
        if (chk_busy) begin
            chk({tag, " busy s1"}, 32'(b1), 32'(eb1));
            chk({tag, " busy s4"}, 32'(b4), 32'(eb4));
        end
        @(posedge clk); #1;
        chk({tag, " done pulse"}, {30'd0, done1, done4}, 32'd0);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int s;
        s = int'(v.sh);
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; shamt = v.sh;
        @(posedge clk); #1;
        start = 1'b0;
        a = 32'hdead_0000; shamt = 5'd9; op = SLL;
        wait_both(1, v.exp, v.exp, 1 + s, 1 + (s + 3) / 4, 1'b1,
                  s, (s + 3) / 4, tag);
    endtask

    initial begin
        int dcnt;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0; start = 1'b0; op = SLL; a = '0; shamt = '0;

        vecs[0]  = '{SRL, 32'h0000_00f0, 5'd4,  32'h0000_000f};
        vecs[1]  = '{SRA, 32'h8000_0000, 5'd31, 32'hffff_ffff};
        vecs[2]  = '{SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[3]  = '{ROR, 32'h0000_0001, 5'd1,  32'h8000_0000};
        vecs[4]  = '{SRL, 32'h0000_1234, 5'd0,  32'h0000_1234};
        vecs[5]  = '{SRL, 32'h0000_ff00, 5'd7,  32'h0000_01fe};
        vecs[6]  = '{SRA, 32'h1234_5678, 5'd0,  32'h1234_5678};
        vecs[7]  = '{ROR, 32'h1234_5678, 5'd0,  32'h1234_5678};
        vecs[8]  = '{ROR, 32'h1234_5678, 5'd8,  32'h7812_3456};
        vecs[9]  = '{SRA, 32'hf000_0000, 5'd4,  32'hff00_0000};
        vecs[10] = '{SRA, 32'h7000_0000, 5'd4,  32'h0700_0000};
        vecs[11] = '{SLL, 32'hdead_beef, 5'd4,  32'head_beef0};
        vecs[12] = '{ROR, 32'h8000_0001, 5'd31, 32'h0000_0003};
        vecs[13] = '{SRL, 32'hffff_ffff, 5'd31, 32'h0000_0001};
        vecs[14] = '{ROR, 32'h0000_000f, 5'd5,  32'h7800_0000};

        #2;
        chk("reset outs s1", {busy1, done1, 30'd0} | (res1 != 0), 32'd0);
        chk("reset res s1", res1, 32'd0);
        chk("reset outs s4", {30'd0, busy4, done4}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulsed mid-BUSY with other operands is ignored.
        @(negedge clk);
        start = 1'b1; op = SRL; a = 32'h0000_f000; shamt = 5'd12;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = SLL; a = 32'h0000_ffff; shamt = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_both(2, 32'h0000_000f, 32'h0000_000f, 13, 4, 1'b0, 0, 0,
                  "midbusy");

        // Start held through DONE: second op accepted with no idle cycle.
        @(negedge clk);
        start = 1'b1; op = SLL; a = 32'h0000_0003; shamt = 5'd1;
        @(posedge clk); #1;
        op = ROR; a = 32'h0000_0001; shamt = 5'd1;
        chk("b2b busy1", {30'd0, busy1, busy4}, 32'd3);
        @(posedge clk); #1;
        chk("b2b done1", {30'd0, done1, done4}, 32'd3);
        chk("b2b res1 s1", res1, 32'h0000_0006);
        chk("b2b res1 s4", res4, 32'h0000_0006);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b no idle", {30'd0, busy1, busy4}, 32'd3);
        @(posedge clk); #1;
        chk("b2b done2", {30'd0, done1, done4}, 32'd3);
        chk("b2b res2 s1", res1, 32'h8000_0000);
        chk("b2b res2 s4", res4, 32'h8000_0000);
        @(posedge clk); #1;
        chk("b2b done end", {30'd0, done1, done4}, 32'd0);

        // Asynchronous reset mid-BUSY.
        @(negedge clk);
        start = 1'b1; op = SLL; a = 32'h0000_00ff; shamt = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-rst busy", {30'd0, busy1, busy4}, 32'd3);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async rst ctl", {28'd0, busy1, done1, busy4, done4}, 32'd0);
        chk("async rst res s1", res1, 32'd0);
        chk("async rst res s4", res4, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done1 || done4 || busy1 || busy4) dcnt++;
        end
        chk("no stale done", 32'(dcnt), 32'd0);
        run_op('{SRL, 32'h0000_0100, 5'd2, 32'h0000_0040}, "post-rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
